seg7_scan: RTL and testbench

SEG7_SCAN -- requirements
Module: seg7_scan

---
 rtl/seg7_scan_pkg.sv | 49 ++++
 rtl/seg7_scan.sv | 82 ++++++++
 tb/tb_seg7_scan.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_pkg.sv
//------------------------------------------------------------------------------
// seg7_scan_pkg : shared seven-segment constants and stopwatch glyph table
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package seg7_scan_pkg;

    // Segment patterns are active-high, bit0 = segment a
    localparam logic [6:0] SEG_ZERO  = 7'h3F;
    localparam logic [6:0] SEG_OFF_N = 7'h7F;
    localparam logic [3:0] AN_OFF_N  = 4'hF;

    localparam logic [6:0] SEG_ONE   = 7'h06;
    localparam logic [6:0] SEG_TWO   = 7'h5B;
    localparam logic [6:0] SEG_THREE = 7'h4F;
    localparam logic [6:0] SEG_FOUR  = 7'h66;
    localparam logic [6:0] SEG_FIVE  = 7'h6D;
    localparam logic [6:0] SEG_SIX   = 7'h7D;
    localparam logic [6:0] SEG_SEVEN = 7'h07;
    localparam logic [6:0] SEG_EIGHT = 7'h7F;
    localparam logic [6:0] SEG_NINE  = 7'h6F;

    typedef enum logic {
        PH_BLANK = 1'b0,
        PH_DRIVE = 1'b1
    } phase_t;

    function automatic logic [6:0] seg7_encode(input logic [3:0] bcd);
        logic [6:0] pat;
        case (bcd)
            4'd0:    pat = SEG_ZERO;
            4'd1:    pat = SEG_ONE;
            4'd2:    pat = SEG_TWO;
            4'd3:    pat = SEG_THREE;
            4'd4:    pat = SEG_FOUR;
            4'd5:    pat = SEG_FIVE;
            4'd6:    pat = SEG_SIX;
            4'd7:    pat = SEG_SEVEN;
            4'd8:    pat = SEG_EIGHT;
            4'd9:    pat = SEG_NINE;
            default: pat = 7'h00;
        endcase
        return pat;
    endfunction

endpackage

`default_nettype wire

// File: rtl/seg7_scan.sv
//------------------------------------------------------------------------------
// seg7_scan : four-digit multiplexed 7-segment scanner with snapshot shadows
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module seg7_scan
    import seg7_scan_pkg::*;
#(
    parameter int DPN = 256,
    parameter int DBN = 16,
    parameter bit LZB = 1'b1,
    parameter int DPL = $clog2(DPN)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] dig_0,
    input  logic [6:0] dig_1,
    input  logic [6:0] dig_2,
    input  logic [6:0] dig_3,
    input  logic [3:0] dp,
    output logic [6:0] seg_n,
    output logic       dp_n,
    output logic [3:0] an_n,
    output logic       frm
);

    logic [DPL-1:0]  r_cnt;
    logic [1:0]      r_idx;
    logic [3:0][6:0] r_sh_dig;
    logic [3:0]      r_sh_dp;

    logic   w_last;
    logic   w_snap;
    logic   w_lz;
    phase_t w_phase;

    assign w_last  = (r_cnt == DPL'(DPN - 1));
    assign w_snap  = (r_cnt == '0) && (r_idx == 2'd0);
    assign w_phase = (r_cnt < DPL'(DBN)) ? PH_BLANK : PH_DRIVE;
    // Leading-zero suppression only ever applies to the ten-minutes digit
    assign w_lz    = LZB && (r_idx == 2'd3) && (r_sh_dig[3] == SEG_ZERO);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_idx    <= 2'd0;
            r_sh_dig <= '0;
            r_sh_dp  <= '0;
            frm      <= 1'b0;
            seg_n    <= SEG_OFF_N;
            dp_n     <= 1'b1;
            an_n     <= AN_OFF_N;
        end else begin
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
            if (w_last) begin
                r_idx <= r_idx + 2'd1;
            end

            // Shadows are loaded while the output is in a blank phase, so a
            // frame never mixes old and new digit data.
            if (w_snap) begin
                r_sh_dig <= {dig_3, dig_2, dig_1, dig_0};
                r_sh_dp  <= dp;
            end
            frm <= w_snap;

            if (w_phase == PH_BLANK || w_lz) begin
                seg_n <= SEG_OFF_N;
                dp_n  <= 1'b1;
                an_n  <= AN_OFF_N;
            end else begin
                seg_n <= ~r_sh_dig[r_idx];
                dp_n  <= ~r_sh_dp[r_idx];
                an_n  <= ~(4'b0001 << r_idx);
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_seg7_scan.sv
//------------------------------------------------------------------------------
// tb_seg7_scan : table-driven and sequence checks for seg7_scan (DPN=8, DBN=2)
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_seg7_scan;

    localparam int DPN = 8;
    localparam int DBN = 2;
    localparam int FRAME = 4 * DPN;

    logic       clk;
    logic       rst;
    logic [6:0] d [4];
    logic [3:0] dp;

    logic [6:0] seg_n0, seg_n1;
    logic       dp_n0, dp_n1;
    logic [3:0] an_n0, an_n1;
    logic       frm0, frm1;

    seg7_scan #(.DPN(DPN), .DBN(DBN), .LZB(1'b0)) u_lzb0 (
        .clk(clk), .rst(rst),
        .dig_0(d[0]), .dig_1(d[1]), .dig_2(d[2]), .dig_3(d[3]), .dp(dp),
        .seg_n(seg_n0), .dp_n(dp_n0), .an_n(an_n0), .frm(frm0)
    );

    seg7_scan #(.DPN(DPN), .DBN(DBN), .LZB(1'b1)) u_lzb1 (
        .clk(clk), .rst(rst),
        .dig_0(d[0]), .dig_1(d[1]), .dig_2(d[2]), .dig_3(d[3]), .dp(dp),
        .seg_n(seg_n1), .dp_n(dp_n1), .an_n(an_n1), .frm(frm1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;
    int e = 0;
    logic [6:0] sh [4];
    logic [3:0] shdp;

    typedef struct packed {
        logic [3:0][6:0] dig;
        logic [3:0]      dpv;
        logic [1:0]      slot;
        logic [3:0]      an0;
        logic [6:0]      seg0;
        logic            dpn0;
        logic [3:0]      an1;
        logic [6:0]      seg1;
        logic            dpn1;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s pos=%0d got %h expected %h", name, e, got, exp);
        end
    endtask

    // Expected {an_n, seg_n, dp_n} for frame position pos, from the bench shadow
    function automatic logic [11:0] model(input int pos, input bit lzb);
        int c;
        int i;
        c = pos % DPN;
        i = (pos / DPN) % 4;
        if (c < DBN) return {4'hF, 7'h7F, 1'b1};
        if (lzb && i == 3 && sh[3] == 7'h3F) return {4'hF, 7'h7F, 1'b1};
        return {~(4'b0001 << i), ~sh[i], ~shdp[i]};
    endfunction

    task automatic step();
        if (e % FRAME == 0) begin
            for (int k = 0; k < 4; k++) sh[k] = d[k];
            shdp = dp;
        end
        @(posedge clk);
        #1;
        chk("out_lzb0", {20'd0, an_n0, seg_n0, dp_n0}, {20'd0, model(e, 1'b0)});
        chk("out_lzb1", {20'd0, an_n1, seg_n1, dp_n1}, {20'd0, model(e, 1'b1)});
        chk("frm0", {31'd0, frm0}, {31'd0, (e % FRAME == 0)});
        chk("frm1", {31'd0, frm1}, {31'd0, (e % FRAME == 0)});
        chk("an_onehot", {31'd0, ($countones(~an_n0) <= 1) && ($countones(~an_n1) <= 1)}, 32'd1);
        e++;
    endtask

    task automatic run_to(input int target);
        while (e <= target) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_out0", {20'd0, an_n0, seg_n0, dp_n0}, {20'd0, 4'hF, 7'h7F, 1'b1});
        chk("rst_out1", {20'd0, an_n1, seg_n1, dp_n1}, {20'd0, 4'hF, 7'h7F, 1'b1});
        chk("rst_frm", {30'd0, frm0, frm1}, 32'd0);
        rst = 1'b0;
        e = 0;
    endtask

    task automatic set_dig(input logic [6:0] a3, input logic [6:0] a2,
                           input logic [6:0] a1, input logic [6:0] a0, input logic [3:0] p);
        d[3] = a3; d[2] = a2; d[1] = a1; d[0] = a0; dp = p;
    endtask

    function automatic vec_t mk(input logic [27:0] dg, input logic [3:0] p, input logic [1:0] s,
                                input logic [3:0] a0, input logic [6:0] s0, input logic q0,
                                input logic [3:0] a1, input logic [6:0] s1, input logic q1);
        vec_t v;
        v.dig = dg; v.dpv = p; v.slot = s;
        v.an0 = a0; v.seg0 = s0; v.dpn0 = q0;
        v.an1 = a1; v.seg1 = s1; v.dpn1 = q1;
        return v;
    endfunction

    int first_frm;
    int second_frm;

    initial begin
        rst = 1'b1;
        set_dig(7'h00, 7'h00, 7'h00, 7'h00, 4'h0);
        for (int k = 0; k < 4; k++) sh[k] = 7'h00;
        shdp = 4'h0;

        // dig field is {dig_3, dig_2, dig_1, dig_0}
        vecs[0] = mk({7'h4F, 7'h5B, 7'h06, 7'h3F}, 4'h0, 2'd0, 4'hE, 7'h40, 1'b1, 4'hE, 7'h40, 1'b1);
        vecs[1] = mk({7'h4F, 7'h5B, 7'h06, 7'h3F}, 4'h0, 2'd1, 4'hD, 7'h79, 1'b1, 4'hD, 7'h79, 1'b1);
        vecs[2] = mk({7'h4F, 7'h5B, 7'h06, 7'h3F}, 4'h0, 2'd2, 4'hB, 7'h24, 1'b1, 4'hB, 7'h24, 1'b1);
        vecs[3] = mk({7'h4F, 7'h5B, 7'h06, 7'h3F}, 4'h0, 2'd3, 4'h7, 7'h30, 1'b1, 4'h7, 7'h30, 1'b1);
        vecs[4] = mk({7'h3F, 7'h5B, 7'h06, 7'h3F}, 4'h8, 2'd3, 4'h7, 7'h40, 1'b0, 4'hF, 7'h7F, 1'b1);
        vecs[5] = mk({7'h4F, 7'h6D, 7'h06, 7'h3F}, 4'h4, 2'd2, 4'hB, 7'h12, 1'b0, 4'hB, 7'h12, 1'b0);
        vecs[6] = mk({7'h4F, 7'h5B, 7'h06, 7'h7F}, 4'h0, 2'd0, 4'hE, 7'h00, 1'b1, 4'hE, 7'h00, 1'b1);
        vecs[7] = mk({7'h4F, 7'h5B, 7'h00, 7'h3F}, 4'h2, 2'd1, 4'hD, 7'h7F, 1'b0, 4'hD, 7'h7F, 1'b0);
        vecs[8] = mk({7'h00, 7'h5B, 7'h06, 7'h3F}, 4'h0, 2'd3, 4'h7, 7'h7F, 1'b1, 4'h7, 7'h7F, 1'b1);
        vecs[9] = mk({7'h3F, 7'h3F, 7'h3F, 7'h3F}, 4'hF, 2'd0, 4'hE, 7'h40, 1'b0, 4'hE, 7'h40, 1'b0);

        for (int v = 0; v < 10; v++) begin
            set_dig(vecs[v].dig[3], vecs[v].dig[2], vecs[v].dig[1], vecs[v].dig[0], vecs[v].dpv);
            do_reset();
            run_to(int'(vecs[v].slot) * DPN + 4);
            chk($sformatf("vec%0d_lzb0", v), {20'd0, an_n0, seg_n0, dp_n0},
                {20'd0, vecs[v].an0, vecs[v].seg0, vecs[v].dpn0});
            chk($sformatf("vec%0d_lzb1", v), {20'd0, an_n1, seg_n1, dp_n1},
                {20'd0, vecs[v].an1, vecs[v].seg1, vecs[v].dpn1});
        end

        // Ten-minutes zero blanked; a new dig_3 appears only from the next frame
        set_dig(7'h3F, 7'h5B, 7'h06, 7'h3F, 4'h0);
        do_reset();
        run_to(12);
        d[3] = 7'h06;
        run_to(28);
        chk("lz_hold_an", {28'd0, an_n1}, 32'hF);
        chk("lz_hold_seg", {25'd0, seg_n1}, 32'h7F);
        run_to(FRAME + 28);
        chk("lz_next_an", {28'd0, an_n1}, 32'h7);
        chk("lz_next_seg", {25'd0, seg_n1}, 32'h79);

        // Mid-frame dig_1 change waits for the frame wrap
        set_dig(7'h4F, 7'h5B, 7'h06, 7'h3F, 4'h0);
        do_reset();
        run_to(20);
        d[1] = 7'h5B;
        run_to(FRAME + 4);
        chk("tear_old_seg", {25'd0, seg_n0}, 32'h40);
        run_to(FRAME + 12);
        chk("tear_new_seg", {25'd0, seg_n0}, 32'h24);
        chk("tear_new_an", {28'd0, an_n0}, 32'hD);

        // Decimal point on digit 2 only in its drive cycles
        set_dig(7'h4F, 7'h5B, 7'h06, 7'h3F, 4'b0100);
        do_reset();
        run_to(16);
        chk("dp_blank", {31'd0, dp_n0}, 32'd1);
        run_to(18);
        chk("dp_drive", {31'd0, dp_n0}, 32'd0);

        // Asynchronous reset in the middle of digit 2 drive
        run_to(20);
        #2;
        rst = 1'b1;
        #1;
        chk("async_an0", {28'd0, an_n0}, 32'hF);
        chk("async_an1", {28'd0, an_n1}, 32'hF);
        chk("async_seg", {25'd0, seg_n0}, 32'h7F);
        @(negedge clk);
        rst = 1'b0;
        e = 0;
        first_frm = -1;
        second_frm = -1;
        while (e < 3 * FRAME && second_frm < 0) begin
            step();
            if (frm0) begin
                if (first_frm < 0) first_frm = e - 1;
                else second_frm = e - 1;
            end
        end
        chk("frm_first_pos", first_frm, 32'd0);
        chk("frm_period", second_frm - first_frm, FRAME);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
